memory_access: RTL
==================

// Module: memory_access
// PURPOSE: Stage 4 of the RV32I pipeline. Registers the execute results, issues LOAD/STORE as single Wishbone (pipelined) transfers, and formats load data.
//   Stalls upstream while a transfer is outstanding, buffers completion until downstream is free, and feeds writeback.
// PARAMETERS:
//   TIMEOUT_CYCLES  255  max cycles in REQ+WAIT before abort with bus error (1..255, 8-bit counter)
// PORTS:
//   clk                 in   1    clock
//   rst                 in   1    synchronous active-high reset
//   clk_en              in   1    upstream instruction valid (execute next_clk_en)
//   stall               in   1    downstream stall; hold outputs
//   flush               in   1    kill instruction entering this stage
//   execute_opcode_type in   `OPCODE_WIDTH  one-hot opcode; `LOAD/`STORE bits used
//   execute_funct3      in   3    size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   execute_result      in   32   ALU result = effective address for LOAD/STORE
//   execute_rs2_data    in   32   store data (low-aligned)
//   execute_rd          in   5    destination register
//   execute_rd_wr_en    in   1    rd write enable
//   execute_rd_wr_data  in   32   rd data for non-load ops
//   memory_rd           out  5    registered rd
//   memory_rd_wr_en     out  1    registered rd write enable (forced 0 on exception)
//   memory_rd_wr_data   out  32   load data (extended) or passed-through rd data
//   memory_exception    out  2    [0] misaligned access, [1] bus timeout
//   next_clk_en         out  1    writeback valid
//   next_stall          out  1    stall upstream stages
//   o_wb_cyc            out  1    bus cycle
//   o_wb_stb            out  1    bus strobe
//   o_wb_we             out  1    1 = store
//   o_wb_addr           out  32   word address {addr[31:2],2'b00}
//   o_wb_data           out  32   store data shifted to byte lane
//   o_wb_sel            out  4    byte enables
//   i_wb_ack            in   1    transfer complete
//   i_wb_stall          in   1    slave not accepting stb
//   i_wb_data           in   32   read word
// BEHAVIOUR:
// - Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-transfer drops cyc/stb at that edge; a late ack is ignored.
// - FSM IDLE->REQ->WAIT->DONE->IDLE. Accept = IDLE & clk_en & !stall & !next_stall & !flush.
// - IDLE, accept, non-mem op: register rd/wr_en/wr_data, next_clk_en<=1 (latency 1).
// - IDLE, accept, LOAD/STORE aligned: latch addr/data/sel/funct3/rd, go REQ, next_clk_en<=0.
//   Misaligned (H: addr[0]; W: addr[1:0]!=0): no bus cycle, memory_exception[0]<=1, wr_en<=0, next_clk_en<=1.
// - IDLE, flush or !clk_en: next_clk_en<=0, no bus cycle. stall & clk_en: hold all outputs.
// - REQ: cyc=stb=1. !i_wb_stall: go WAIT (or DONE if ack same cycle). WAIT: cyc=1, stb=0; ack -> DONE.
// - On ack: capture i_wb_data, drop cyc. Other acks outside REQ/WAIT are ignored.
// - Timeout counter runs in REQ/WAIT; reaching TIMEOUT_CYCLES drops cyc/stb, memory_exception[1]<=1, wr_en<=0, go DONE.
// - DONE: if !stall, present result, next_clk_en<=1, go IDLE; else hold in DONE.
// - next_stall = (state!=IDLE), combinational. Minimum load/store latency is 3 edges (accept, ack, DONE).
// - Store lanes: SB sel=1<<a[1:0], data={4{rs2[7:0]}}; SH sel=a[1]?1100:0011, data={2{rs2[15:0]}}; SW sel=1111.
// - Load: select byte/half by a[1:0]; B/H sign-extend, BU/HU zero-extend; W unchanged.
// - Store completion: rd_wr_en<=0. Flush while busy is ignored (the bus transfer is not aborted).
// TESTING:
// - LW 0x100, ack 1 cycle after stb, data 0xDEADBEEF -> wb_addr 0x100, sel 1111, memory_rd_wr_data 0xDEADBEEF, next_clk_en high 3 edges after accept.
// - LB addr 0x103, word 0x80FF_FF01 -> sel 1000 ignored on read, result 0xFFFFFF80; LBU -> 0x00000080.
// - SH rs2=0x1234ABCD addr 0x202 -> we=1, sel 1100, wb_data 0xABCDABCD, rd_wr_en 0.
// - LW addr 0x101 -> no cyc, memory_exception=01 after 1 edge; LW with no ack for 255 cycles -> cyc drops, exception=10.
// - i_wb_stall high 3 cycles, then ack with downstream stall held 2 cycles -> stb held 3 cycles, stays in DONE, outputs stable until stall falls.
// - ADD result 0x55 back-to-back with flush pulse -> 1-cycle pass-through, flushed op gives next_clk_en 0; rst during WAIT -> cyc 0 next edge.

Source files
------------

// File: rtl/memory_access.sv
// RV32I memory stage: issues LOAD/STORE as single pipelined Wishbone
// transfers, formats load data and hands results to writeback.
module memory_access #(
    parameter int OPCODE_WIDTH   = 11,
    parameter int LOAD_BIT       = 2,
    parameter int STORE_BIT      = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [OPCODE_WIDTH-1:0] execute_opcode_type,
    input  logic [2:0]              execute_funct3,
    input  logic [31:0]             execute_result,
    input  logic [31:0]             execute_rs2_data,
    input  logic [4:0]              execute_rd,
    input  logic                    execute_rd_wr_en,
    input  logic [31:0]             execute_rd_wr_data,
    output logic [4:0]              memory_rd,
    output logic                    memory_rd_wr_en,
    output logic [31:0]             memory_rd_wr_data,
    output logic [1:0]              memory_exception,
    output logic                    next_clk_en,
    output logic                    next_stall,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [31:0]             o_wb_addr,
    output logic [31:0]             o_wb_data,
    output logic [3:0]              o_wb_sel,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_stall,
    input  logic [31:0]             i_wb_data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  f3_q, f3_d;
    logic        isld_q, isld_d;
    logic [4:0]  prd_q, prd_d;
    logic        pwen_q, pwen_d;
    logic        tmo_q, tmo_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic [31:0] res_q, res_d;
    logic [1:0]  exc_q, exc_d;
    logic        vld_q, vld_d;

    logic        is_load, is_store, misal;
    logic [1:0]  size;
    logic [3:0]  sel_c;
    logic [31:0] wdat_c;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    assign is_load  = execute_opcode_type[LOAD_BIT];
    assign is_store = execute_opcode_type[STORE_BIT];
    assign size     = execute_funct3[1:0];
    assign misal    = ((size == 2'b01) && execute_result[0]) ||
                      ((size == 2'b10) && (execute_result[1:0] != 2'b00));

    always_comb begin
        sel_c  = 4'b1111;
        wdat_c = execute_rs2_data;
        case (size)
            2'b00: begin
                sel_c  = 4'b0001 << execute_result[1:0];
                wdat_c = {4{execute_rs2_data[7:0]}};
            end
            2'b01: begin
                sel_c  = execute_result[1] ? 4'b1100 : 4'b0011;
                wdat_c = {2{execute_rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Byte/half lane selection uses the latched byte offset.
    assign shifted = rdata_q >> {addr_q[1:0], 3'b000};
    assign byte_v  = shifted[7:0];
    assign half_v  = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b100:  load_v = {24'd0, byte_v};
            3'b101:  load_v = {16'd0, half_v};
            default: load_v = rdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        f3_d    = f3_q;
        isld_d  = isld_q;
        prd_d   = prd_q;
        pwen_d  = pwen_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wen_d   = wen_q;
        res_d   = res_q;
        exc_d   = exc_q;
        vld_d   = vld_q;
        case (state_q)
            IDLE: begin
                if (stall) begin
                    vld_d = vld_q;
                end else if (flush || !clk_en) begin
                    vld_d = 1'b0;
                end else if ((is_load || is_store) && misal) begin
                    rd_d  = execute_rd;
                    wen_d = 1'b0;
                    res_d = execute_rd_wr_data;
                    exc_d = 2'b01;
                    vld_d = 1'b1;
                end else if (is_load || is_store) begin
                    addr_d  = execute_result;
                    wdat_d  = wdat_c;
                    sel_d   = sel_c;
                    we_d    = is_store;
                    f3_d    = execute_funct3;
                    isld_d  = is_load;
                    prd_d   = execute_rd;
                    pwen_d  = execute_rd_wr_en;
                    tmo_d   = 1'b0;
                    tcnt_d  = 8'd0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    vld_d   = 1'b0;
                    state_d = REQ;
                end else begin
                    rd_d  = execute_rd;
                    wen_d = execute_rd_wr_en;
                    res_d = execute_rd_wr_data;
                    exc_d = 2'b00;
                    vld_d = 1'b1;
                end
            end
            REQ, WAIT: begin
                if (i_wb_ack) begin
                    rdata_d = i_wb_data;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = DONE;
                end else if (tcnt_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                    if (state_q == REQ && !i_wb_stall) begin
                        stb_d   = 1'b0;
                        state_d = WAIT;
                    end
                end
            end
            DONE: begin
                tcnt_d = 8'd0;
                if (!stall) begin
                    rd_d    = prd_q;
                    wen_d   = pwen_q && isld_q && !tmo_q;
                    res_d   = load_v;
                    exc_d   = {tmo_q, 1'b0};
                    vld_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            f3_q    <= '0;
            isld_q  <= 1'b0;
            prd_q   <= '0;
            pwen_q  <= 1'b0;
            tmo_q   <= 1'b0;
            rdata_q <= '0;
            rd_q    <= '0;
            wen_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            f3_q    <= f3_d;
            isld_q  <= isld_d;
            prd_q   <= prd_d;
            pwen_q  <= pwen_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wen_q   <= wen_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            vld_q   <= vld_d;
        end
    end

    assign memory_rd         = rd_q;
    assign memory_rd_wr_en   = wen_q;
    assign memory_rd_wr_data = res_q;
    assign memory_exception  = exc_q;
    assign next_clk_en       = vld_q;
    assign next_stall        = (state_q != IDLE);
    assign o_wb_cyc          = cyc_q;
    assign o_wb_stb          = stb_q;
    assign o_wb_we           = we_q;
    assign o_wb_addr         = {addr_q[31:2], 2'b00};
    assign o_wb_data         = wdat_q;
    assign o_wb_sel          = sel_q;

endmodule
